// File: rtl/alu_operand_sequencer.sv
// ==========================================================================
// alu_operand_sequencer : loads A/B nibbles, waits for the ALU, captures result
// Revision: 1.0
// ==========================================================================
`default_nettype none

module alu_operand_sequencer #(
  parameter int EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic [3:0] res_in,
  input  logic       carry_in,
  input  logic       ovf_in,
  input  logic       zero_in,
  input  logic       neg_in,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] result_q,
  output logic [3:0] flags_q,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(EXEC_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       exec_last;

  // Handshake outputs are pure decodes of the state register.
  assign ready = (state == S_IDLE) || (state == S_WAIT_B);
  assign busy  = (state == S_EXEC) || (state == S_DONE);
  assign done  = (state == S_DONE);

  always_comb begin
    accept    = data_valid && ready;
    exec_last = (state == S_EXEC) && (wait_cnt == WAIT_LAST);
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_WAIT_B;
      S_WAIT_B: if (accept) state_nxt = S_EXEC;
      S_EXEC:   if (exec_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      result_q <= 4'd0;
      flags_q  <= 4'd0;
      op_count <= 8'd0;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && accept) begin
        alu_a <= data_in;
      end
      if ((state == S_WAIT_B) && accept) begin
        alu_b    <= data_in;
        wait_cnt <= 4'd0;
      end
      // The count is bumped on the capture edge so it is current while done is high.
      if (state == S_EXEC) begin
        if (exec_last) begin
          result_q <= res_in;
          flags_q  <= {neg_in, zero_in, ovf_in, carry_in};
          op_count <= op_count + 8'd1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural 4-bit ALU stage attached.
`default_nettype none

module tb_alu_operand_sequencer;

  localparam int EXEC_WAIT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_valid;
  logic [3:0] res_in;
  logic       carry_in, ovf_in, zero_in, neg_in;
  logic [3:0] alu_a, alu_b, result_q, flags_q;
  logic       ready, busy, done;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.EXEC_WAIT(EXEC_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .res_in(res_in), .carry_in(carry_in), .ovf_in(ovf_in), .zero_in(zero_in),
    .neg_in(neg_in), .alu_a(alu_a), .alu_b(alu_b), .ready(ready), .busy(busy),
    .done(done), .result_q(result_q), .flags_q(flags_q), .op_count(op_count)
  );

  // ALU stage: returns {N,Z,V,C,result}; C is carry for add, borrow for sub.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (a[1:0])
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      2'b01: begin
        r = a - b;
        c = (a < b);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[3], (r == 4'd0), v, c, r};
  endfunction

  assign {neg_in, zero_in, ovf_in, carry_in, res_in} = alu_model(alu_a, alu_b);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] flg;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_seen = 0;
  int         last_done = -1;
  bit         burst = 1'b0;
  bit         cnt_pending = 1'b0;
  logic [7:0] exp_ops = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_pending) begin
      check("op_count", {24'd0, op_count}, {24'd0, exp_ops});
      cnt_pending = 1'b0;
    end
    if (!rst_n) exp_ops = 8'd0;
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("result_q", {28'd0, result_q}, {28'd0, e.res});
        check("flags_q", {28'd0, flags_q}, {28'd0, e.flg});
        check("alu_a_at_done", {28'd0, alu_a}, {28'd0, e.a});
        check("alu_b_at_done", {28'd0, alu_b}, {28'd0, e.b});
        check("done_latency_cycle", cyc, e.cyc);
      end
      exp_ops = exp_ops + 8'd1;
      cnt_pending = 1'b1;
      if (burst && last_done >= 0) check("throughput", cyc - last_done, EXEC_WAIT + 3);
      last_done = cyc;
    end
  end

  task automatic send(input logic [3:0] v, input bit hold, output int edge_cyc);
    bit ok;
    ok = 1'b0;
    data_in = v;
    data_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    edge_cyc = cyc;
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] r,
                    input logic [3:0] f, input bit push, input bit hold);
    int t;
    send(a, hold, t);
    send(b, hold, t);
    if (push) sb.push_back('{a: a, b: b, res: r, flg: f, cyc: t + EXEC_WAIT});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_alu_a"}, {28'd0, alu_a}, 32'd0);
    check({tag, "_alu_b"}, {28'd0, alu_b}, 32'd0);
    check({tag, "_result_q"}, {28'd0, result_q}, 32'd0);
    check({tag, "_flags_q"}, {28'd0, flags_q}, 32'd0);
    check({tag, "_op_count"}, {24'd0, op_count}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int t;
    logic [7:0] m;
    int base;
    // Reset with data_valid asserted: reset must win.
    rst_n = 1'b0;
    data_valid = 1'b1;
    data_in = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    data_valid = 1'b0;
    check_zero_state("reset");

    // Directed ALU operations.
    op(4'b0100, 4'b0011, 4'b0111, 4'b0000, 1'b1, 1'b0);
    op(4'b0100, 4'b1100, 4'b0000, 4'b0101, 1'b1, 1'b0);
    op(4'b0101, 4'b0110, 4'b1111, 4'b1001, 1'b1, 1'b0);
    op(4'b0110, 4'b1100, 4'b0100, 4'b0000, 1'b1, 1'b0);
    op(4'b1011, 4'b0100, 4'b1111, 4'b1000, 1'b1, 1'b0);
    op(4'b1001, 4'b0100, 4'b0101, 4'b0010, 1'b1, 1'b0);
    op(4'b0100, 4'b0100, 4'b1000, 4'b1010, 1'b1, 1'b0);
    wait_idle();

    // data_valid during EXEC and DONE is ignored; next accept loads A.
    op(4'b0101, 4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b1);
    data_in = 4'hF;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    check("ignored_alu_a", {28'd0, alu_a}, 32'h5);
    check("ignored_alu_b", {28'd0, alu_b}, 32'h3);
    send(4'b1110, 1'b0, t);
    check("reload_alu_a", {28'd0, alu_a}, 32'hE);
    check("hold_alu_b", {28'd0, alu_b}, 32'h3);
    check("hold_result_q", {28'd0, result_q}, 32'h2);
    check("hold_flags_q", {28'd0, flags_q}, 32'h0);
    send(4'b0101, 1'b0, t);
    sb.push_back('{a: 4'b1110, b: 4'b0101, res: 4'b0100, flg: 4'b0000, cyc: t + EXEC_WAIT});
    wait_idle();

    // Reset mid-EXEC aborts the operation.
    op(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("in_exec_busy", {31'd0, busy}, 32'd1);
    pulse_reset();
    check_zero_state("abort");
    repeat (4) @(posedge clk);
    #1;
    check("abort_op_count", {24'd0, op_count}, 32'd0);
    op(4'b0011, 4'b1010, 4'b1011, 4'b1000, 1'b1, 1'b0);
    wait_idle();

    // 256 back-to-back operations from reset with data_valid held high.
    pulse_reset();
    base = done_seen;
    last_done = -1;
    burst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      m = alu_model(i[3:0], i[7:4]);
      op(i[3:0], i[7:4], m[3:0], m[7:4], 1'b1, 1'b1);
    end
    data_valid = 1'b0;
    wait_idle();
    burst = 1'b0;
    check("burst_done_count", done_seen - base, 256);
    check("burst_op_count_wrap", {24'd0, op_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
